mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-requester arbiter sharing a single SRAM-like memory bus between the instruction fetch port (ICache side) and the data access port (DCache side, MEM stage). It captures one request at a time and holds its address/data/control stable on the memory bus. It sequences the transaction through address and response phases and routes the response back to the owner. Only one transaction is outstanding at a time; conflicts are resolved round-robin; a fetch can be cancelled on pipeline flush.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  flush pulse; discards response of in-flight fetch
- inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word
- data_wstrb  in  DATA_W/8  byte enables for stores
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted (1-cycle pulse)
- data_data_ok  out  1  load data valid / store complete (1-cycle pulse)
- data_rdata  out  DATA_W  load data
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  (as data side)  memory bus request fields
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in ADDR or RESP

## Operation
- FSM: IDLE, ADDR, RESP.
- IDLE: if any request is pending, grant one requester. X_addr_ok is asserted combinationally in that same cycle. Request fields are latched into internal registers, owner is recorded, and state moves to ADDR.
- Grant: a single requester wins. If both are pending, the winner is the requester opposite last_grant. last_grant resets to INST, so the first conflict goes to DATA. last_grant updates on every grant.
- ADDR: mem_req=1 with latched fields (stable until handshake). On mem_addr_ok the state moves to RESP and mem_req drops the next cycle. mem_data_ok in ADDR is a protocol violation and is ignored.
- RESP: on mem_data_ok, owner's X_data_ok = 1 and X_rdata = mem_rdata (combinational pass-through), and state moves to IDLE. The non-owner's data_ok stays 0.
- Stores: mem_rdata is ignored. data_data_ok still pulses on completion.
- inst_cancel is honoured while owner=INST in ADDR or RESP. It sets the discard flag, and the bus transaction still completes normally. inst_data_ok is suppressed on completion and the flag clears on returning to IDLE.
- inst_cancel in IDLE or with owner=DATA has no effect. Cancel coinciding with mem_data_ok suppresses that response.
- Next capture is only possible once back in IDLE (no back-to-back overlap).

## Timing
- Reset: state=IDLE, last_grant=INST, discard=0, latched fields=0.
  - All outputs are 0: mem_req, mem_*, addr_ok/data_ok, rdata, busy.
- Reset mid-transaction aborts to IDLE immediately with no data_ok. The memory side shares rst.
- Accepted at cycle T (addr_ok high) -> mem_req high from T+1.
- mem_addr_ok at T+1 -> RESP at T+2. Earliest X_data_ok is T+2, with IDLE at T+3.
- Earliest next X_addr_ok is T+3, so peak throughput is one transaction per 3 cycles with a zero-wait memory.
- Waits on mem_addr_ok / mem_data_ok are unbounded and the FSM holds.
- X_addr_ok is never asserted outside IDLE. A requester dropping req before addr_ok is legal and simply is not granted.

## Structure
Shared package CPU_Defines.svh gets:
- the arb_state_t enum (IDLE/ADDR/RESP)
- the owner_t enum (INST/DATA)
- the size constants SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2

One sub-module is natural: arb_rr2, the two-way round-robin picker (req_i[1:0], last_grant -> grant one-hot, combinational). The FSM, request latch and discard flag live in the top.

## Test plan
- Single fetch: inst_req, addr 0xBFC00000, mem_addr_ok and mem_data_ok with zero wait, rdata 0x24080001. Required: inst_addr_ok at T, mem_addr 0xBFC00000 at T+1, inst_data_ok with 0x24080001 at T+2, busy low at T+3.
- Conflict: inst_req and data_req rise the same cycle after reset. Required: DATA granted first, INST next. With both held continuously, grants strictly alternate over 6 transactions.
- Store with 3-cycle mem_addr_ok stall: data_addr 0x80000010, wdata 0xDEADBEEF, wstrb 0xF. Required: all mem_* fields stable for 3 cycles, then data_data_ok pulses once.
- Fetch cancel: inst_cancel pulsed while in RESP waiting 4 cycles. Required: no inst_data_ok, busy clears after mem_data_ok, and the following data request is served normally.
- Async reset asserted while in ADDR. Required: all outputs 0 without waiting for a clock edge. After release, a fresh fetch completes with normal latency.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter: FSM states, owner encoding, access sizes.
package mem_bus_arbiter_pkg;

  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: on a conflict the requester opposite the last grant wins.
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,       // [0] = INST, [1] = DATA
  input  owner_t     last_grant,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    if (req_i == 2'b11) begin
      grant_c = (last_grant == INST) ? 2'b10 : 2'b01;
    end else begin
      grant_c = req_i;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and data ports; one transaction in flight,
// round-robin on conflicts, and fetch responses can be discarded on a pipeline flush.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [SIZE_W-1:0]   data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [SIZE_W-1:0]   mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  owner_t              r_owner;
  owner_t              r_last_grant;
  logic                r_discard;
  logic                r_wr;
  logic [SIZE_W-1:0]   r_size;
  logic [STRB_W-1:0]   r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [1:0]          w_grant;
  logic                w_grant_inst;
  logic                w_grant_data;
  logic                w_resp_done;
  logic                w_inst_done;

  arb_rr2 u_arb_rr2 (
    .req_i      ({data_req, inst_req}),
    .last_grant (r_last_grant),
    .grant_c    (w_grant)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grants are only considered in IDLE; bus waits are unbounded in ADDR and RESP.
  always_comb begin
    w_next_state = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_inst = w_grant[0];
        w_grant_data = w_grant[1];
        if (|w_grant) w_next_state = ADDR;
      end
      ADDR: begin
        if (mem_addr_ok) w_next_state = RESP;
      end
      RESP: begin
        if (mem_data_ok) begin
          w_resp_done  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch: fetches are always word reads with no byte enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= INST;
      r_last_grant <= INST;
      r_wr         <= 1'b0;
      r_size       <= '0;
      r_wstrb      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant_inst) begin
      r_owner      <= INST;
      r_last_grant <= INST;
      r_wr         <= 1'b0;
      r_size       <= SIZE_WORD;
      r_wstrb      <= '0;
      r_addr       <= inst_addr;
      r_wdata      <= '0;
    end else if (w_grant_data) begin
      r_owner      <= DATA;
      r_last_grant <= DATA;
      r_wr         <= data_wr;
      r_size       <= data_size;
      r_wstrb      <= data_wstrb;
      r_addr       <= data_addr;
      r_wdata      <= data_wdata;
    end
  end

  // Discard flag: a flushed fetch still finishes on the bus but its response is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_discard <= 1'b0;
    end else if (w_next_state == IDLE) begin
      r_discard <= 1'b0;
    end else if (r_state != IDLE && r_owner == INST && inst_cancel) begin
      r_discard <= 1'b1;
    end
  end

  assign w_inst_done  = w_resp_done && (r_owner == INST) && !r_discard && !inst_cancel;

  // Handshakes are gated by reset so every output reads 0 while reset is held.
  assign inst_addr_ok = rst & w_grant_inst;
  assign data_addr_ok = rst & w_grant_data;
  assign inst_data_ok = w_inst_done;
  assign inst_rdata   = w_inst_done ? mem_rdata : '0;
  assign data_data_ok = w_resp_done && (r_owner == DATA);
  assign data_rdata   = (data_data_ok && !r_wr) ? mem_rdata : '0;

  assign mem_req      = (r_state == ADDR);
  assign mem_wr       = r_wr;
  assign mem_size     = r_size;
  assign mem_wstrb    = r_wstrb;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations plus a random
// phase checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_cancel = 1'b0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                            mem_req, mem_wr, mem_size, mem_wstrb, busy}), 64'd0);
    chk({tag, "_rdata"}, 64'({inst_rdata, data_rdata}), 64'd0);
    chk({tag, "_mem"}, 64'({mem_addr, mem_wdata}), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Model: at most one outstanding transaction; it is either awaiting the address
  // handshake or awaiting its response. last grant: 0 = fetch, 1 = data.
  bit          m_out, m_adone, m_owner, m_disc, m_last;
  bit          m_wr;
  bit [1:0]    m_size;
  bit [3:0]    m_wstrb;
  bit [31:0]   m_addr, m_wdata;

  always @(negedge clk) begin : model_check
    bit e_iaok, e_daok, e_mreq, e_ido, e_ddo;
    if (!rst) begin
      chk_all_zero("reset");
      m_out = 1'b0; m_adone = 1'b0; m_disc = 1'b0; m_last = 1'b0;
    end else begin
      e_iaok = !m_out && inst_req && (!data_req || m_last);
      e_daok = !m_out && data_req && (!inst_req || !m_last);
      e_mreq = m_out && !m_adone;
      e_ido  = m_out && m_adone && mem_data_ok && !m_owner && !m_disc && !inst_cancel;
      e_ddo  = m_out && m_adone && mem_data_ok && m_owner;
      chk("addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'({e_iaok, e_daok}));
      chk("data_ok", 64'({inst_data_ok, data_data_ok}), 64'({e_ido, e_ddo}));
      chk("mem_req_busy", 64'({mem_req, busy}), 64'({e_mreq, m_out}));
      if (e_mreq) begin
        chk("mem_cmd", 64'({mem_wr, mem_size, mem_addr}), 64'({m_wr, m_size, m_addr}));
        if (m_owner) chk("mem_wpayload", 64'({mem_wstrb, mem_wdata}), 64'({m_wstrb, m_wdata}));
      end
      if (e_ido) chk("inst_rdata", 64'(inst_rdata), 64'(mem_rdata));
      if (e_ddo && !m_wr) chk("data_rdata", 64'(data_rdata), 64'(mem_rdata));
      if (m_out) begin
        if (!m_owner && inst_cancel) m_disc = 1'b1;
        if (!m_adone) begin
          if (mem_addr_ok) m_adone = 1'b1;
        end else if (mem_data_ok) begin
          m_out = 1'b0;
          m_disc = 1'b0;
        end
      end else if (e_iaok) begin
        m_out = 1'b1; m_adone = 1'b0; m_owner = 1'b0; m_last = 1'b0; m_disc = 1'b0;
        m_wr = 1'b0; m_size = 2'd2; m_addr = inst_addr;
      end else if (e_daok) begin
        m_out = 1'b1; m_adone = 1'b0; m_owner = 1'b1; m_last = 1'b1; m_disc = 1'b0;
        m_wr = data_wr; m_size = data_size; m_wstrb = data_wstrb;
        m_addr = data_addr; m_wdata = data_wdata;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ng, ndok, nido;
    bit iacc, dacc;
    repeat (3) step();
    rst = 1'b1;

    // Conflict right after reset: data first, then strict alternation.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0040;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0100;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
    ng = 0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      smp();
      if (inst_addr_ok || data_addr_ok) begin
        chk("conflict_grant", 64'({data_addr_ok, inst_addr_ok}),
            (ng % 2 == 0) ? 64'd2 : 64'd1);
        ng++;
      end
      step();
    end
    chk("conflict_count", 64'(ng), 64'd6);
    inst_req = 1'b0; data_req = 1'b0;
    repeat (4) step();

    // Single zero-wait fetch.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000; mem_rdata = 32'h2408_0001;
    smp(); chk("fetch_addr_ok", 64'(inst_addr_ok), 64'd1);
    step(); inst_req = 1'b0;
    smp(); chk("fetch_mem", 64'({mem_req, mem_addr}), 64'({1'b1, 32'hBFC0_0000}));
    step();
    smp(); chk("fetch_data", 64'({inst_data_ok, inst_rdata}), 64'({1'b1, 32'h2408_0001}));
    step();
    smp(); chk("fetch_busy_clear", 64'(busy), 64'd0);
    step();

    // Store with a 3-cycle address stall; fields must stay latched.
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    smp(); chk("store_addr_ok", 64'(data_addr_ok), 64'd1);
    step();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h1234_5678; data_wdata = 32'h0;
    ndok = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_addr_ok = 1'b1;
      smp();
      chk("store_fields", 64'({mem_req, mem_wr, mem_size, mem_wstrb, mem_addr}),
          64'({1'b1, 1'b1, 2'd2, 4'hF, 32'h8000_0010}));
      chk("store_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
      ndok += int'(data_data_ok);
      step();
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    smp(); chk("store_done", 64'(data_data_ok), 64'd1); ndok += int'(data_data_ok);
    step(); mem_data_ok = 1'b0;
    smp(); chk("store_busy_clear", 64'(busy), 64'd0); ndok += int'(data_data_ok);
    chk("store_dok_once", 64'(ndok), 64'd1);
    step();

    // Fetch cancelled while waiting in the response phase.
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100; mem_addr_ok = 1'b1;
    smp(); chk("cancel_addr_ok", 64'(inst_addr_ok), 64'd1);
    step(); inst_req = 1'b0;
    smp();
    step(); mem_addr_ok = 1'b0; mem_rdata = 32'hCAFE_0000;
    nido = 0;
    for (int k = 0; k < 4; k++) begin
      inst_cancel = (k == 1);
      smp(); nido += int'(inst_data_ok);
      step();
    end
    inst_cancel = 1'b0; mem_data_ok = 1'b1;
    smp(); chk("cancel_suppressed", 64'(inst_data_ok), 64'd0); nido += int'(inst_data_ok);
    step(); mem_data_ok = 1'b0;
    smp(); chk("cancel_busy_clear", 64'(busy), 64'd0);
    chk("cancel_no_dok", 64'(nido), 64'd0);
    step();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0020;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1357_2468;
    smp(); chk("post_cancel_addr_ok", 64'(data_addr_ok), 64'd1);
    step(); data_req = 1'b0;
    smp();
    step();
    smp(); chk("post_cancel_load", 64'({data_data_ok, data_rdata}), 64'({1'b1, 32'h1357_2468}));
    step();

    // Asynchronous reset while the fetch waits in the address phase.
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    smp(); chk("rst_fetch_addr_ok", 64'(inst_addr_ok), 64'd1);
    step(); inst_req = 1'b0;
    smp(); chk("rst_in_addr", 64'(mem_req), 64'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    step();
    smp();
    step(); rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
    smp(); chk("fresh_addr_ok", 64'(inst_addr_ok), 64'd1);
    step(); inst_req = 1'b0;
    smp(); chk("fresh_mem", 64'({mem_req, mem_addr}), 64'({1'b1, 32'hBFC0_0300}));
    step();
    smp(); chk("fresh_data", 64'({inst_data_ok, inst_rdata}), 64'({1'b1, 32'h0BAD_F00D}));
    step();
    smp(); chk("fresh_busy_clear", 64'(busy), 64'd0);

    // Random traffic: requests held until accepted, random bus stalls and flushes.
    iacc = 1'b0; dacc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (iacc || !inst_req) begin
        inst_req  = 1'($urandom_range(0, 1));
        inst_addr = $urandom;
      end
      if (dacc || !data_req) begin
        data_req   = 1'($urandom_range(0, 1));
        data_wr    = 1'($urandom_range(0, 1));
        data_size  = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = 1'($urandom_range(0, 1));
      mem_data_ok = 1'($urandom_range(0, 1));
      mem_rdata   = $urandom;
      inst_cancel = ($urandom_range(0, 7) == 0);
      smp();
      iacc = inst_addr_ok;
      dacc = data_addr_ok;
    end
    step();
    inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
